num_display_scan: RTL

- Output-side counterpart of the keypad number-entry path.
- Takes the accumulated 29-bit hex value and shows it on an 8-digit multiplexed common-anode seven-segment display.
- Latches the value on a load strobe, time-multiplexes one digit per scan slot, decodes each nibble to segments, and flags each completed frame.

---
 rtl/num_display_scan_pkg.sv | 28 ++
 rtl/hex_to_seg.sv | 32 +++
 rtl/num_display_scan.sv | 96 +++++++++
 3 files changed

// File: rtl/num_display_scan_pkg.sv
// Shared constants for the seven-segment scan display path: digit count,
// digit-index type and active-low segment patterns {g,f,e,d,c,b,a}.
package num_display_scan_pkg;

  localparam int unsigned DIGITS_DEF  = 8;
  localparam int unsigned DIGIT_IDX_W = $clog2(DIGITS_DEF);

  typedef logic [DIGIT_IDX_W-1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
  import num_display_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n_c
);

  always_comb begin
    o_seg_n_c = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg_n_c = SEG_0;
      4'h1: o_seg_n_c = SEG_1;
      4'h2: o_seg_n_c = SEG_2;
      4'h3: o_seg_n_c = SEG_3;
      4'h4: o_seg_n_c = SEG_4;
      4'h5: o_seg_n_c = SEG_5;
      4'h6: o_seg_n_c = SEG_6;
      4'h7: o_seg_n_c = SEG_7;
      4'h8: o_seg_n_c = SEG_8;
      4'h9: o_seg_n_c = SEG_9;
      4'hA: o_seg_n_c = SEG_A;
      4'hB: o_seg_n_c = SEG_B;
      4'hC: o_seg_n_c = SEG_C;
      4'hD: o_seg_n_c = SEG_D;
      4'hE: o_seg_n_c = SEG_E;
      4'hF: o_seg_n_c = SEG_F;
      default: o_seg_n_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/num_display_scan.sv
// Multiplexed 8-digit hex display driver: latches a value, scans one digit per slot.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero nibble.
module num_display_scan
  import num_display_scan_pkg::*;
#(
  parameter int unsigned WIDTH    = 29,
  parameter int unsigned DIGITS   = DIGITS_DEF,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WIDTH-1:0]  num_in,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic [DIGITS-1:0] an_n,
  output logic              frame_done
);

  localparam int unsigned VAL_W = DIGITS * 4;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);

  logic [VAL_W-1:0]  r_value;
  logic [PRE_W-1:0]  r_presc;
  logic [IDX_W-1:0]  r_digit;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;
  logic              r_dp;
  logic              r_frame;

  logic              w_slot_end;
  logic              w_last_digit;
  logic [3:0]        w_nibble;
  logic [6:0]        w_seg;
  logic              w_blank;

  assign w_slot_end   = (r_presc == PRE_W'(SCAN_DIV - 1));
  assign w_last_digit = (r_digit == IDX_W'(DIGITS - 1));
  assign w_nibble     = r_value[{r_digit, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .i_nibble  (w_nibble),
    .o_seg_n_c (w_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Index of the most significant non-zero nibble; zero value keeps digit 0 lit.
  logic [IDX_W-1:0] w_top;

  always_comb begin
    w_top = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_value[4*i +: 4] != 4'h0) begin
        w_top = IDX_W'(i);
      end
    end
  end

  assign w_blank = (r_digit > w_top);
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
      r_presc <= '0;
      r_digit <= '0;
      r_seg   <= SEG_BLANK;
      r_an    <= '1;
      r_dp    <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      if (load) begin
        r_value <= VAL_W'(num_in);
      end
      if (w_slot_end) begin
        r_presc <= '0;
        r_digit <= w_last_digit ? '0 : r_digit + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_frame <= w_slot_end & w_last_digit;
      r_an    <= w_blank ? '1 : ~(DIGITS'(1) << r_digit);
      r_seg   <= w_blank ? SEG_BLANK : w_seg;
      r_dp    <= 1'b1;
    end
  end

  assign seg_n      = r_seg;
  assign an_n       = r_an;
  assign dp_n       = r_dp;
  assign frame_done = r_frame;

endmodule
